mmio_timer: RTL and testbench
=============================

MMIO_TIMER -- requirements
Module: mmio_timer

Interface
REQ-001 SHALL have parameter XLEN, default 64, data/counter width (32 or 64).
REQ-002 SHALL have parameter NCH, default 2, compare channel count (1..8).
REQ-003 SHALL have parameter PW, default 16, prescaler width (1..16).
REQ-004 SHALL have port clk  input  1  single clock, all state on posedge.
REQ-005 SHALL have port rstn  input  1  reset, asynchronous, active-low.
REQ-006 SHALL have port cen  input  1  access enable.
REQ-007 SHALL have port wr  input  1  1=write, 0=read.
REQ-008 SHALL have port addr  input  8  byte offset.
REQ-009 SHALL have port wdata  input  XLEN  write data.
REQ-010 SHALL have port rdata  output  XLEN  read data.
REQ-011 SHALL have port error  output  1  access fault.
REQ-012 SHALL have port irq  output  1  interrupt, level.

Function
REQ-013 SHALL map registers at 8-byte stride: 0x00 MTIME; 0x08 CTRL; 0x10 STATUS; 0x18+8*i CMP[i]; 0x58+8*i PERIOD[i] (macro only).
REQ-014 SHALL use CTRL bit0 = EN, bits[8+:NCH] = IE, bits[16+:PW] = PRESC; other bits read 0, ignore writes.
REQ-015 SHALL return rdata combinationally for cen&!wr on a mapped offset; 0 otherwise.
REQ-016 SHALL drive error combinationally when cen=1 and addr is unmapped or addr[2:0]!=0; faulting writes change no state.
REQ-017 SHALL commit writes at the posedge with cen&wr; zero wait states.
REQ-018 SHALL count the prescaler 0..PRESC while EN=1, wrapping to 0; tick is asserted on the cycle the count equals PRESC; PRESC=0 ticks every cycle.
REQ-019 SHALL clear the prescaler to 0 and hold it while EN=0.
REQ-020 SHALL increment MTIME by 1 on tick, wrapping 2^XLEN-1 -> 0.
REQ-021 SHALL give a MTIME write priority over a same-cycle tick; the written value is loaded and the prescaler is not reset.
REQ-022 SHALL set STATUS[i] at the edge where MTIME's new value equals CMP[i] as the result of a tick; MTIME writes never set STATUS.
REQ-023 SHALL clear STATUS[i] on a write with wdata[i]=1 (W1C); a same-cycle set wins over clear.
REQ-024 SHALL drive irq = |(STATUS & IE) from registers, no combinational path from bus inputs.
REQ-025 SHALL, when a CMP[i] write and a match on i occur in the same cycle, use the old CMP[i] for the match and then load the written value.

Reset
REQ-026 SHALL, while rstn=0, asynchronously clear MTIME, CTRL, STATUS, prescaler and PERIOD to 0, set CMP[i] to all-ones, and hold irq=0.
REQ-027 SHALL abandon any in-progress prescale count on reset; the first tick after release occurs PRESC+1 cycles after EN is set.

Configuration
REQ-028 SHALL, with TIMER_AUTORELOAD_EN defined, on a match on channel i with PERIOD[i]!=0, load CMP[i] with CMP[i]+PERIOD[i] modulo 2^XLEN at the same edge; PERIOD[i]=0 leaves CMP[i] unchanged.
REQ-029 SHALL, with TIMER_AUTORELOAD_EN undefined, leave CMP[i] changed only by writes, omit the PERIOD registers, and fault offsets 0x58+ with error=1.

Verification
REQ-030 SHALL cover: CTRL=EN, PRESC=3 -> MTIME reads 0,0,0,0,1 on ticks every 4 cycles; MTIME=10 after 44 enabled cycles.
REQ-031 SHALL cover: CMP0=5, IE0=1, PRESC=0 -> STATUS0 and irq rise on the edge MTIME becomes 5; W1C 0x1 drops irq next cycle.
REQ-032 SHALL cover: MTIME written 2^XLEN-1, EN=1, PRESC=0 -> next value 0; CMP0=0 sets STATUS0.
REQ-033 SHALL cover: read 0x07 or 0xF8 -> error=1, rdata=0; write 0xF8 -> no register changes.
REQ-034 SHALL cover: TIMER_AUTORELOAD_EN, CMP0=4, PERIOD0=4 -> STATUS0 sets at MTIME 4, CMP0 reads 8; set at 8 after W1C, CMP0 reads 12.
REQ-035 SHALL cover: rstn pulsed low mid-count with irq=1 -> irq=0 and all registers at reset values within the same cycle, before the next posedge.

Source files
------------

// File: rtl/mmio_timer.sv
// mmio_timer: memory-mapped free-running timer with NCH compare channels and a level interrupt.
// Defining TIMER_AUTORELOAD_EN adds per-channel PERIOD registers that advance CMP[i] on each match.
`timescale 1ns/1ps
module mmio_timer #(
  parameter int XLEN = 64,
  parameter int NCH  = 2,
  parameter int PW   = 16
) (
  input  logic            clk,
  input  logic            rstn,
  input  logic            cen,
  input  logic            wr,
  input  logic [7:0]      addr,
  input  logic [XLEN-1:0] wdata,
  output logic [XLEN-1:0] rdata,
  output logic            error,
  output logic            irq
);
  localparam logic [4:0] IDX_MTIME  = 5'd0;
  localparam logic [4:0] IDX_CTRL   = 5'd1;
  localparam logic [4:0] IDX_STATUS = 5'd2;
  localparam int         IDX_CMP    = 3;
  localparam int         IDX_PER    = 11;

  logic [XLEN-1:0] mtime_q, mtime_d;
  logic            en_q, en_d;
  logic [NCH-1:0]  ie_q, ie_d;
  logic [PW-1:0]   presc_q, presc_d;
  logic [PW-1:0]   psc_q, psc_d;
  logic [NCH-1:0]  status_q, status_d;
  logic [XLEN-1:0] cmp_q [NCH];
  logic [XLEN-1:0] cmp_d [NCH];
  logic            irq_q, irq_d;
`ifdef TIMER_AUTORELOAD_EN
  logic [XLEN-1:0] per_q [NCH];
  logic [XLEN-1:0] per_d [NCH];
  logic [NCH-1:0]  per_hit_s;
`endif

  logic [4:0]      idx_s;
  logic            aligned_s, mapped_s, wr_ok_s, rd_ok_s, tick_s, mtime_wr_s;
  logic [NCH-1:0]  cmp_hit_s, match_s;
  logic [XLEN-1:0] mtime_inc_s, rd_mux_s, ctrl_rd_s;

  // Address decode, fault detection and read-data mux
  always_comb begin
    idx_s     = addr[7:3];
    aligned_s = (addr[2:0] == 3'd0);
    for (int i = 0; i < NCH; i++) begin
      cmp_hit_s[i] = (idx_s == 5'(IDX_CMP + i));
`ifdef TIMER_AUTORELOAD_EN
      per_hit_s[i] = (idx_s == 5'(IDX_PER + i));
`endif
    end
`ifdef TIMER_AUTORELOAD_EN
    mapped_s = (idx_s <= IDX_STATUS) | (|cmp_hit_s) | (|per_hit_s);
`else
    mapped_s = (idx_s <= IDX_STATUS) | (|cmp_hit_s);
`endif
    error   = cen & ~(aligned_s & mapped_s);
    wr_ok_s = cen & wr & aligned_s & mapped_s;
    rd_ok_s = cen & ~wr & aligned_s & mapped_s;

    ctrl_rd_s           = '0;
    ctrl_rd_s[0]        = en_q;
    ctrl_rd_s[8 +: NCH] = ie_q;
    ctrl_rd_s[16 +: PW] = presc_q;
    case (idx_s)
      IDX_MTIME:  rd_mux_s = mtime_q;
      IDX_CTRL:   rd_mux_s = ctrl_rd_s;
      IDX_STATUS: rd_mux_s = XLEN'(status_q);
      default:    rd_mux_s = '0;
    endcase
    for (int i = 0; i < NCH; i++) begin
      rd_mux_s = rd_mux_s | (cmp_hit_s[i] ? cmp_q[i] : '0);
`ifdef TIMER_AUTORELOAD_EN
      rd_mux_s = rd_mux_s | (per_hit_s[i] ? per_q[i] : '0);
`endif
    end
    rdata = rd_ok_s ? rd_mux_s : '0;
  end

  // Next-state: prescaler, counter, control, compare and status
  always_comb begin
    tick_s      = en_q & (psc_q == presc_q);
    mtime_inc_s = mtime_q + XLEN'(1'b1);
    mtime_wr_s  = wr_ok_s & (idx_s == IDX_MTIME);

    if (!en_q) begin
      psc_d = '0;
    end else if (tick_s) begin
      psc_d = '0;
    end else begin
      psc_d = psc_q + PW'(1'b1);
    end

    if (mtime_wr_s) begin
      mtime_d = wdata;
    end else if (tick_s) begin
      mtime_d = mtime_inc_s;
    end else begin
      mtime_d = mtime_q;
    end

    if (wr_ok_s && (idx_s == IDX_CTRL)) begin
      en_d    = wdata[0];
      ie_d    = wdata[8 +: NCH];
      presc_d = wdata[16 +: PW];
    end else begin
      en_d    = en_q;
      ie_d    = ie_q;
      presc_d = presc_q;
    end

    // A match uses the pre-write CMP value; a same-cycle write lands afterwards
    for (int i = 0; i < NCH; i++) begin
      match_s[i] = tick_s & ~mtime_wr_s & (mtime_inc_s == cmp_q[i]);
      if (wr_ok_s && cmp_hit_s[i]) begin
        cmp_d[i] = wdata;
`ifdef TIMER_AUTORELOAD_EN
      end else if (match_s[i] && (per_q[i] != '0)) begin
        cmp_d[i] = cmp_q[i] + per_q[i];
`endif
      end else begin
        cmp_d[i] = cmp_q[i];
      end
`ifdef TIMER_AUTORELOAD_EN
      if (wr_ok_s && per_hit_s[i]) begin
        per_d[i] = wdata;
      end else begin
        per_d[i] = per_q[i];
      end
`endif
    end

    if (wr_ok_s && (idx_s == IDX_STATUS)) begin
      status_d = (status_q & ~wdata[NCH-1:0]) | match_s;
    end else begin
      status_d = status_q | match_s;
    end
    irq_d = |(status_d & ie_d);
  end

  // State registers with asynchronous active-low reset
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      mtime_q  <= '0;
      en_q     <= 1'b0;
      ie_q     <= '0;
      presc_q  <= '0;
      psc_q    <= '0;
      status_q <= '0;
      irq_q    <= 1'b0;
      for (int i = 0; i < NCH; i++) begin
        cmp_q[i] <= '1;
`ifdef TIMER_AUTORELOAD_EN
        per_q[i] <= '0;
`endif
      end
    end else begin
      mtime_q  <= mtime_d;
      en_q     <= en_d;
      ie_q     <= ie_d;
      presc_q  <= presc_d;
      psc_q    <= psc_d;
      status_q <= status_d;
      irq_q    <= irq_d;
      for (int i = 0; i < NCH; i++) begin
        cmp_q[i] <= cmp_d[i];
`ifdef TIMER_AUTORELOAD_EN
        per_q[i] <= per_d[i];
`endif
      end
    end
  end

  assign irq = irq_q;
endmodule

// File: tb/tb_mmio_timer.sv
// Scoreboard bench for mmio_timer: each bus access pushes its expected rdata/error/irq,
// and a negedge monitor pops and compares whenever the DUT is presented with an access.
`timescale 1ns/1ps
module tb_mmio_timer;
  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic        cen = 1'b0;
  logic        wr = 1'b0;
  logic [7:0]  addr = 8'h00;
  logic [63:0] wdata = 64'd0;
  logic [63:0] rdata;
  logic        error;
  logic        irq;

  mmio_timer dut (
    .clk(clk), .rstn(rstn), .cen(cen), .wr(wr), .addr(addr),
    .wdata(wdata), .rdata(rdata), .error(error), .irq(irq)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [63:0] rd;
    logic        err;
    logic        ci;
    logic        irq;
  } exp_t;

  exp_t  q[$];
  string nq[$];
  int    total = 0;
  int    bad = 0;
  localparam logic [63:0] ONES = 64'hFFFF_FFFF_FFFF_FFFF;

  task automatic drv(input logic w, input logic [7:0] a, input logic [63:0] d,
                     input logic [63:0] er, input logic ee, input int ei, input string nm);
    exp_t e;
    cen = 1'b1; wr = w; addr = a; wdata = d;
    e.rd = er; e.err = ee; e.ci = (ei >= 0); e.irq = (ei > 0);
    q.push_back(e);
    nq.push_back(nm);
  endtask

  task automatic acc(input logic w, input logic [7:0] a, input logic [63:0] d,
                     input logic [63:0] er, input logic ee, input int ei, input string nm);
    @(posedge clk); #1;
    drv(w, a, d, er, ee, ei, nm);
  endtask

  task automatic rd(input logic [7:0] a, input logic [63:0] er, input int ei, input string nm);
    acc(1'b0, a, 64'd0, er, 1'b0, ei, nm);
  endtask

  task automatic wrt(input logic [7:0] a, input logic [63:0] d, input string nm);
    acc(1'b1, a, d, 64'd0, 1'b0, -1, nm);
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk); #1;
      cen = 1'b0; wr = 1'b0;
    end
  endtask

  // Monitor: every presented access is checked against the head of the scoreboard
  always @(negedge clk) begin
    exp_t  e;
    string nm;
    if (cen) begin
      total++;
      if (q.size() == 0) begin
        bad++;
        $display("FAIL unexpected_access: addr=%h with empty scoreboard", addr);
      end else begin
        e  = q.pop_front();
        nm = nq.pop_front();
        if (rdata !== e.rd || error !== e.err || (e.ci && irq !== e.irq)) begin
          bad++;
          $display("FAIL %s: got rdata=%h error=%b irq=%b, want rdata=%h error=%b irq=%b(chk=%b)",
                   nm, rdata, error, irq, e.rd, e.err, e.irq, e.ci);
        end
      end
    end
  end

  initial begin
    #50000;
    $display("FAIL timeout: bench did not complete");
    $fatal(1);
  end

  initial begin
    repeat (3) @(posedge clk);
    #1 rstn = 1'b1;

    rd(8'h00, 64'd0, 0, "rst_mtime");
    rd(8'h08, 64'd0, 0, "rst_ctrl");
    rd(8'h10, 64'd0, 0, "rst_status");
    rd(8'h18, ONES, 0, "rst_cmp0");
    rd(8'h20, ONES, 0, "rst_cmp1");
    acc(1'b0, 8'h28, 64'd0, 64'd0, 1'b1, -1, "cmp2_unmapped");

    // EN with PRESC=3: one tick every 4 cycles
    wrt(8'h08, 64'h0000_0000_0003_0001, "ctrl_en_p3");
    for (int k = 0; k < 4; k++) rd(8'h00, 64'd0, -1, "p3_mtime0");
    rd(8'h00, 64'd1, -1, "p3_mtime1");
    idle(38);
    rd(8'h00, 64'd10, -1, "p3_mtime10");
    rd(8'h00, 64'd11, -1, "p3_mtime11");
    wrt(8'h08, 64'd0, "ctrl_off");
    rd(8'h00, 64'd11, -1, "off_hold_a");
    idle(5);
    rd(8'h00, 64'd11, -1, "off_hold_b");

    // Compare match raises STATUS0/irq, W1C drops it
    wrt(8'h00, 64'd0, "mtime_0");
    wrt(8'h18, 64'd5, "cmp0_5");
    wrt(8'h08, 64'h101, "ctrl_en_ie0");
    for (int k = 0; k < 5; k++) rd(8'h10, 64'd0, 0, "sts_before_match");
    rd(8'h10, 64'd1, 1, "sts_match5");
    rd(8'h00, 64'd6, 1, "mtime6_irq");
    wrt(8'h10, 64'd1, "w1c_0");
    rd(8'h10, 64'd0, 0, "sts_after_w1c");
    wrt(8'h08, 64'd0, "ctrl_off2");

    // Counter wrap to zero matches CMP0=0
    wrt(8'h00, ONES, "mtime_max");
    wrt(8'h18, 64'd0, "cmp0_0");
    wrt(8'h08, 64'h101, "ctrl_en_ie0_b");
    rd(8'h00, ONES, 0, "wrap_pre");
    rd(8'h00, 64'd0, 1, "wrap_zero");
    rd(8'h10, 64'd1, 1, "wrap_sts");
    wrt(8'h08, 64'd0, "ctrl_off3");
    wrt(8'h10, 64'd3, "w1c_all");
    rd(8'h10, 64'd0, 0, "sts_clr2");

    // Faulting accesses change nothing
    acc(1'b0, 8'h07, 64'd0, 64'd0, 1'b1, -1, "rd_07");
    acc(1'b0, 8'hF8, 64'd0, 64'd0, 1'b1, -1, "rd_F8");
    acc(1'b1, 8'hF8, ONES, 64'd0, 1'b1, -1, "wr_F8");
    acc(1'b1, 8'h09, ONES, 64'd0, 1'b1, -1, "wr_09");
    rd(8'h00, 64'd3, 0, "mtime_unchanged");
    rd(8'h08, 64'd0, 0, "ctrl_unchanged");
    rd(8'h18, 64'd0, 0, "cmp0_unchanged");
    rd(8'h20, ONES, 0, "cmp1_unchanged");

`ifdef TIMER_AUTORELOAD_EN
    wrt(8'h00, 64'd0, "ar_mtime0");
    wrt(8'h58, 64'd4, "ar_per0");
    wrt(8'h18, 64'd4, "ar_cmp0");
    wrt(8'h08, 64'h101, "ar_en");
    for (int k = 0; k < 4; k++) rd(8'h10, 64'd0, 0, "ar_sts_pre");
    rd(8'h10, 64'd1, 1, "ar_sts_at4");
    rd(8'h18, 64'd8, 1, "ar_cmp0_8");
    wrt(8'h10, 64'd1, "ar_w1c");
    rd(8'h10, 64'd0, 0, "ar_sts_clr");
    rd(8'h10, 64'd1, 1, "ar_sts_at8");
    rd(8'h18, 64'd12, 1, "ar_cmp0_12");
    rd(8'h58, 64'd4, 1, "ar_per0_rd");
    wrt(8'h08, 64'd0, "ar_off");
    wrt(8'h10, 64'd3, "ar_w1c_all");
`else
    acc(1'b0, 8'h58, 64'd0, 64'd0, 1'b1, -1, "per0_unmapped");
    acc(1'b1, 8'h58, 64'd4, 64'd0, 1'b1, -1, "per0_wr_fault");
`endif

    // Asynchronous reset mid-count with irq asserted
    wrt(8'h00, 64'd0, "pr_mtime0");
    wrt(8'h18, 64'd3, "pr_cmp0_3");
    wrt(8'h08, 64'h0000_0000_0002_0101, "pr_en_p2");
    idle(12);
    rd(8'h10, 64'd1, 1, "pre_rst_irq");
    @(posedge clk); #1;
    rstn = 1'b0;
    drv(1'b0, 8'h00, 64'd0, 64'd0, 1'b0, 0, "rst_async_mtime");
    rd(8'h08, 64'd0, 0, "in_rst_ctrl");
    rd(8'h10, 64'd0, 0, "in_rst_status");
    rd(8'h18, ONES, 0, "in_rst_cmp0");
    idle(1);
    rstn = 1'b1;
    rd(8'h00, 64'd0, 0, "post_rst_mtime");
    idle(3);
    rd(8'h00, 64'd0, 0, "post_rst_mtime_hold");

    idle(2);
    if (q.size() != 0) begin
      total++;
      bad++;
      $display("FAIL scoreboard_drain: %0d expected entries left, want 0", q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
